// File: rtl/divider_arbiter_pkg.sv
// Shared types and helpers for the shared iterative divider and its requester arbiter.
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index over n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/divider_arbiter_core.sv
// Restoring shift-subtract datapath: one quotient bit per step, MSB first.
module divider_iter_core #(
  parameter int dividend_width = 12,
  parameter int divisor_width  = 3
) (
  input  logic                      clock,
  input  logic                      load,
  input  logic                      step,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic [dividend_width-1:0] quotient,
  output logic [divisor_width-1:0]  remainder
);

  logic [dividend_width-1:0] quot_q;
  logic [divisor_width-1:0]  rem_q;
  logic [divisor_width-1:0]  dvs_q;
  logic [divisor_width:0]    trial;
  logic [divisor_width:0]    diff;
  logic                      fits;

  // The dividend shifts out of quot_q's MSB while quotient bits fill its LSB.
  assign trial = {rem_q, quot_q[dividend_width-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign fits  = (trial >= {1'b0, dvs_q});

  always_ff @(posedge clock) begin
    if (load) begin
      quot_q <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
    end else if (step) begin
      rem_q  <= fits ? diff[divisor_width-1:0] : trial[divisor_width-1:0];
      quot_q <= {quot_q[dividend_width-2:0], fits};
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative divider among NUM_REQ requesters,
// returning each result on a single tagged valid/ready response channel.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int dividend_width = 12,
  parameter int divisor_width  = 3,
  parameter int NUM_REQ        = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*dividend_width-1:0]   req_dividend,
  input  logic [NUM_REQ*divisor_width-1:0]    req_divisor,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]        rsp_id,
  output logic [dividend_width-1:0]           rsp_quotient,
  output logic [divisor_width-1:0]            rsp_remainder,
  output logic                                rsp_div_by_zero,
  output logic                                busy
);

  localparam int IW = id_width(NUM_REQ);
  localparam int CW = id_width(dividend_width);

  state_t                    state;
  state_t                    state_nxt;
  logic [IW-1:0]             rr_ptr;
  logic [IW-1:0]             grant_idx;
  logic [IW-1:0]             hi_idx;
  logic [IW-1:0]             lo_idx;
  logic [IW-1:0]             id_q;
  logic                      hi_any;
  logic                      any_valid;
  logic [CW-1:0]             bit_cnt;
  logic                      load;
  logic                      step;
  logic                      dbz_q;
  logic                      done;
  logic [dividend_width-1:0] sel_dividend;
  logic [divisor_width-1:0]  sel_divisor;
  logic [dividend_width-1:0] quotient;
  logic [divisor_width-1:0]  remainder;

  // Masked priority pick: lowest valid index above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IW'(i);
        if (i > int'(rr_ptr)) begin
          hi_idx = IW'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign any_valid = |req_valid;
  assign grant_idx = hi_any ? hi_idx : lo_idx;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == grant_idx) begin
        sel_dividend = req_dividend[i*dividend_width +: dividend_width];
        sel_divisor  = req_divisor[i*divisor_width +: divisor_width];
        req_ready[i] = (state == IDLE) && any_valid;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          load      = 1'b1;
          state_nxt = (sel_divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (bit_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= IW'(NUM_REQ - 1);
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        rr_ptr  <= grant_idx;
        bit_cnt <= CW'(dividend_width - 1);
      end else if (step) begin
        bit_cnt <= bit_cnt - CW'(1);
      end
    end
  end

  // Tag and divide-by-zero flag are data; outputs are gated by DONE instead of reset.
  always_ff @(posedge clock) begin
    if (load) begin
      id_q  <= grant_idx;
      dbz_q <= (sel_divisor == '0);
    end
  end

  divider_iter_core #(
    .dividend_width (dividend_width),
    .divisor_width  (divisor_width)
  ) u_core (
    .clock     (clock),
    .load      (load),
    .step      (step),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // On divide-by-zero the core was loaded but never stepped, so it still holds the dividend.
  assign done            = (state == DONE);
  assign rsp_valid       = done;
  assign busy            = (state != IDLE);
  assign rsp_id          = done ? id_q : '0;
  assign rsp_div_by_zero = done & dbz_q;
  assign rsp_quotient    = done ? (dbz_q ? '1 : quotient) : '0;
  assign rsp_remainder   = done ? (dbz_q ? quotient[divisor_width-1:0] : remainder) : '0;

endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter: table vectors, scoreboard and corner sequences.
module tb_divider_arbiter;

  localparam int DW = 12;
  localparam int VW = 3;
  localparam int NR = 4;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] req_dividend;
  logic [NR*VW-1:0] req_divisor;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [DW-1:0]  rsp_quotient;
  logic [VW-1:0]  rsp_remainder;
  logic           rsp_div_by_zero;
  logic           busy;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          id;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
  } vec_t;

  typedef struct {
    int            id;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  divider_arbiter #(
    .dividend_width (DW),
    .divisor_width  (VW),
    .NUM_REQ        (NR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dividend    (req_dividend),
    .req_divisor     (req_divisor),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_quotient    (rsp_quotient),
    .rsp_remainder   (rsp_remainder),
    .rsp_div_by_zero (rsp_div_by_zero),
    .busy            (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    e.id = id;
    if (b == '0) begin
      e.q = '1; e.r = a[VW-1:0]; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / DW'(b); e.r = VW'(a % DW'(b)); e.dbz = 1'b0; e.lat = DW + 1;
    end
    return e;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.id = v.id; e.q = v.q; e.r = v.r; e.dbz = v.dbz;
    e.lat = v.dbz ? 1 : DW + 1;
    return e;
  endfunction

  // Observes accepts and responses on the falling edge; pops the scoreboard on each handshake.
  task automatic monitor();
    exp_t e;
    int   acc  = 0;
    int   brun = 0;
    int   lat  = 0;
    bit   seen = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        seen = 1'b0;
        continue;
      end
      if (req_ready != '0) begin
        chk("grant_onehot", 32'($onehot(req_ready)), 1);
        chk("grant_while_busy", 32'(busy), 0);
        acc  = cyc;
        brun = 0;
      end else if (busy) begin
        brun++;
      end
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        lat  = cyc - acc;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_quotient", 32'(rsp_quotient), 32'(e.q));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(e.r));
          chk("rsp_dbz", 32'(rsp_div_by_zero), 32'(e.dbz));
          chk("rsp_latency", lat, e.lat);
          chk("busy_span", brun, cyc - acc);
        end
        seen = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; returns in the accept cycle with the sampled grant vector.
  task automatic wait_grant(output logic [NR-1:0] g);
    int n = 0;
    g = '0;
    while (g == '0 && n < 60) begin
      #1;
      g = req_ready;
      if (g == '0) begin
        @(posedge clock); #1;
        n++;
      end
    end
    chk("grant_timeout", 32'(g != '0), 1);
  endtask

  task automatic issue(input exp_t e, input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [NR-1:0] g;
    req_dividend[e.id*DW +: DW] = a;
    req_divisor[e.id*VW +: VW]  = b;
    req_valid[e.id]             = 1'b1;
    wait_grant(g);
    if (g != '0) begin
      chk("grant_id", 32'(g), 32'(1) << e.id);
      sb.push_back(e);
      @(posedge clock); #1;
    end
    req_valid[e.id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    chk("drain_timeout", 32'(sb.size() == 0), 1);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [18:0]   snap;
    int            cnt;
    exp_t          e;
    int            rid;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    reset        = 1'b1;
    rsp_ready    = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;

    tbl[0]  = '{2, 12'd100,  3'd7, 12'd14,   3'd2, 1'b0};
    tbl[1]  = '{0, 12'd4095, 3'd1, 12'd4095, 3'd0, 1'b0};
    tbl[2]  = '{1, 12'd5,    3'd7, 12'd0,    3'd5, 1'b0};
    tbl[3]  = '{3, 12'd37,   3'd0, 12'hFFF,  3'd5, 1'b1};
    tbl[4]  = '{0, 12'd2048, 3'd5, 12'd409,  3'd3, 1'b0};
    tbl[5]  = '{1, 12'd4095, 3'd7, 12'd585,  3'd0, 1'b0};
    tbl[6]  = '{2, 12'd1234, 3'd3, 12'd411,  3'd1, 1'b0};
    tbl[7]  = '{3, 12'd0,    3'd4, 12'd0,    3'd0, 1'b0};
    tbl[8]  = '{0, 12'd6,    3'd6, 12'd1,    3'd0, 1'b0};
    tbl[9]  = '{1, 12'd4094, 3'd0, 12'hFFF,  3'd6, 1'b1};
    tbl[10] = '{2, 12'd13,   3'd2, 12'd6,    3'd1, 1'b0};
    tbl[11] = '{3, 12'd7,    3'd7, 12'd1,    3'd0, 1'b0};

    fork
      monitor();
    join_none

    repeat (2) @(posedge clock);
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_data", {rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero}, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Fairness: all requesters valid continuously from reset; grants rotate from 0.
    for (int r = 0; r < NR; r++) begin
      req_dividend[r*DW +: DW] = DW'(100 * (r + 1) + 7);
      req_divisor[r*VW +: VW]  = VW'(r + 2);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      rid = k % NR;
      wait_grant(g);
      chk("rr_order", 32'(g), 32'(1) << rid);
      sb.push_back(model(rid, req_dividend[rid*DW +: DW], req_divisor[rid*VW +: VW]));
      @(posedge clock); #1;
      req_dividend[rid*DW +: DW] = DW'($urandom);
      req_divisor[rid*VW +: VW]  = VW'($urandom_range(1, 7));
      if (k == 7) req_valid = '0;
    end
    drain();

    for (int i = 0; i < 12; i++) begin
      issue(to_exp(tbl[i]), tbl[i].a, tbl[i].b);
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      rid = int'($urandom_range(0, NR - 1));
      ra  = DW'($urandom);
      rb  = VW'($urandom_range(0, 7));
      issue(model(rid, ra, rb), ra, rb);
      drain();
    end

    // Consumer stalls 20 cycles in DONE while another requester waits.
    rsp_ready = 1'b0;
    issue(tbl[5].id == 1 ? model(1, 12'd300, 3'd7) : model(1, 12'd300, 3'd7), 12'd300, 3'd7);
    req_dividend[2*DW +: DW] = 12'd50;
    req_divisor[2*VW +: VW]  = 3'd3;
    req_valid[2]             = 1'b1;
    cnt = 0;
    while (!rsp_valid && cnt < 40) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk("stall_rsp_timeout", 32'(rsp_valid), 1);
    snap = {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero};
    repeat (20) begin
      @(posedge clock); #1;
      chk("stall_hold", {rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_by_zero}, 32'(snap));
      chk("stall_no_grant", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #2;
    chk("grant_after_release", 32'(req_ready), 32'b0100);
    e = '{2, 12'd16, 3'd2, 1'b0, DW + 1};
    sb.push_back(e);
    @(posedge clock); #1;
    req_valid[2] = 1'b0;
    drain();

    // Reset while the bit counter is at 6: no response, pointer back to requester 0.
    issue(model(1, 12'd1000, 3'd3), 12'd1000, 3'd3);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("midrun_reset_valid", 32'(rsp_valid), 0);
    chk("midrun_reset_busy", 32'(busy), 0);
    chk("midrun_reset_quot", 32'(rsp_quotient), 0);
    chk("midrun_reset_ready", 32'(req_ready), 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (rsp_valid || busy) cnt++;
    end
    chk("no_rsp_after_reset", cnt, 0);
    req_dividend[0*DW +: DW] = 12'd77;
    req_divisor[0*VW +: VW]  = 3'd5;
    req_dividend[3*DW +: DW] = 12'd9;
    req_divisor[3*VW +: VW]  = 3'd2;
    req_valid = 4'b1001;
    wait_grant(g);
    chk("post_reset_grant", 32'(g), 32'b0001);
    sb.push_back(model(0, 12'd77, 3'd5));
    @(posedge clock); #1;
    req_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
